// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size encodings, FSM states,
// load extension, store merge and alignment check.
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 2 * BYTE_W;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    RESP
  } state_e;

  // Reserved size behaves exactly like a word everywhere.
  function automatic logic is_sub_word(input size_e size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] data,
                                             input size_e           size,
                                             input logic            sgn);
    logic [XLEN-1:0] result;
    case (size)
      SZ_BYTE: result = {{(XLEN-BYTE_W){sgn & data[BYTE_W-1]}}, data[BYTE_W-1:0]};
      SZ_HALF: result = {{(XLEN-HALF_W){sgn & data[HALF_W-1]}}, data[HALF_W-1:0]};
      default: result = data;
    endcase
    return result;
  endfunction

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_data,
                                            input logic [XLEN-1:0] wdata,
                                            input size_e           size);
    logic [XLEN-1:0] result;
    case (size)
      SZ_BYTE: result = {old_data[XLEN-1:BYTE_W], wdata[BYTE_W-1:0]};
      SZ_HALF: result = {old_data[XLEN-1:HALF_W], wdata[HALF_W-1:0]};
      default: result = wdata;
    endcase
    return result;
  endfunction

  function automatic logic misaligned(input logic [1:0] addr_lo, input size_e size);
    logic result;
    case (size)
      SZ_BYTE: result = 1'b0;
      SZ_HALF: result = addr_lo[0];
      default: result = |addr_lo;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational data path of the load/store unit: size extraction with sign/zero
// extension for loads, and low byte/half replacement for read-modify-write stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  size_e           size,
  input  logic            sgn,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged_data
);

  assign load_data   = extend(rdata, size, sgn);
  assign merged_data = merge(rdata, wdata, size);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per transaction, read-modify-write for
// sub-word stores. Optional alignment checking is enabled by defining ALIGN_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int WIDTH_ADD = 32,
  parameter int BYTE      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [WIDTH_ADD-1:0] req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 resp_valid,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic                 resp_err,
  output logic [WIDTH_ADD-1:0] mem_address,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_write_en,
  input  logic [WIDTH-1:0]     mem_rdata
);

  state_e               state, state_next;
  logic                 write_q;
  size_e                size_q;
  logic                 signed_q;
  logic [WIDTH_ADD-1:0] addr_q;
  logic [WIDTH-1:0]     wdata_q;
  logic [WIDTH-1:0]     rdata_q;
  logic [WIDTH-1:0]     merged_q;
  logic [WIDTH-1:0]     load_data;
  logic [WIDTH-1:0]     merged_data;
  logic                 accept;
  logic                 misaligned_in;

  assign accept = req_valid && req_ready;

`ifdef ALIGN_CHECK_EN
  logic err_q;

  assign misaligned_in = misaligned(req_addr[1:0], size_e'(req_size));
  assign resp_err      = resp_valid && err_q;

  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= misaligned_in;
  end
`else
  assign misaligned_in = 1'b0;
  assign resp_err      = 1'b0;
`endif

  lsu_byte_lane u_byte_lane (
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .size        (size_q),
    .sgn         (signed_q),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  // NOTE: every register here is reset and updated with <= so all flops sample
  // the same pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            write_q  <= req_write;
            size_q   <= size_e'(req_size);
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
          end
        end
        ACCESS: begin
          if (!write_q) rdata_q  <= load_data;
          else          merged_q <= merged_data;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_write_en = 1'b0;
    mem_wdata    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = misaligned_in ? RESP : ACCESS;
      end
      ACCESS: begin
        if (!write_q) begin
          state_next = RESP;
        end else if (is_sub_word(size_q)) begin
          state_next = MERGE;
        end else begin
          mem_wdata    = wdata_q;
          mem_write_en = 1'b1;
          state_next   = RESP;
        end
      end
      MERGE: begin
        mem_wdata    = merged_q;
        mem_write_en = 1'b1;
        state_next   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // rdata_q is cleared on accept and only loaded for loads, so stores and
  // misaligned accesses return zero.
  assign mem_address = addr_q;
  assign resp_rdata  = resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-addressed
// little-endian memory model (combinational read, clocked full-word write).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_write_en;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [64];
  logic        poke_en;
  logic [31:0] poke_addr;
  logic [31:0] poke_data;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_write_en (mem_write_en),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = {mem[6'(mem_address + 32'd3)], mem[6'(mem_address + 32'd2)],
                      mem[6'(mem_address + 32'd1)], mem[6'(mem_address)]};

  always @(posedge clk) begin
    if (mem_write_en) begin
      for (int i = 0; i < 4; i++) mem[6'(mem_address + 32'(i))] <= mem_wdata[8*i +: 8];
    end
    if (poke_en) begin
      for (int i = 0; i < 4; i++) mem[6'(poke_addr + 32'(i))] <= poke_data[8*i +: 8];
    end
  end

  function automatic logic [31:0] peek(input logic [31:0] addr);
    return {mem[6'(addr + 32'd3)], mem[6'(addr + 32'd2)], mem[6'(addr + 32'd1)], mem[6'(addr)]};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    poke_en   = 1'b1;
    poke_addr = addr;
    poke_data = data;
    step();
    poke_en = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  // One complete transaction; latency is counted from the accept edge to the
  // edge that samples resp_valid, bounded to six cycles.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_writes);
    int lat;
    int writes;
    drive(wr, sz, sg, addr, wd);
    check({tag, " ready_before"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    lat       = 1;
    writes    = 0;
    while (!resp_valid && lat < 6) begin
      if (mem_write_en) begin
        writes++;
        last_wdata = mem_wdata;
        check({tag, " write_addr"}, mem_address, addr);
      end
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " err"}, 32'(resp_err), 32'(exp_err));
    check({tag, " writes"}, 32'(writes), 32'(exp_writes));
    step();
    check({tag, " pulse_end"}, 32'(resp_valid), 32'd0);
    check({tag, " ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    poke_en    = 1'b0;
    poke_addr  = '0;
    poke_data  = '0;
    last_wdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    step();
    step();
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst mem_write_en", 32'(mem_write_en), 32'd0);
    check("rst mem_address", mem_address, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    step();

    // Word store then word load.
    run_req("st_w", 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
    check("st_w wdata", last_wdata, 32'hDEADBEEF);
    check("st_w mem", peek(32'h8), 32'hDEADBEEF);
    run_req("ld_w", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

    // Sub-word stores via read-modify-write; upper store-data bits must be ignored.
    poke(32'h8, 32'h11223344);
    run_req("st_b", 1'b1, 2'b00, 1'b0, 32'h8, 32'hFFFFFFAA, 3, 32'h0, 1'b0, 1);
    check("st_b wdata", last_wdata, 32'h112233AA);
    check("st_b mem", peek(32'h8), 32'h112233AA);
    poke(32'hC, 32'h55667788);
    run_req("st_h", 1'b1, 2'b01, 1'b0, 32'hC, 32'h1234BEEF, 3, 32'h0, 1'b0, 1);
    check("st_h mem", peek(32'hC), 32'h5566BEEF);

    // Load extension.
    poke(32'h4, 32'h000080F0);
    run_req("ld_bs", 1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 2, 32'hFFFFFFF0, 1'b0, 0);
    run_req("ld_bu", 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 2, 32'h000000F0, 1'b0, 0);
    run_req("ld_hs", 1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 2, 32'hFFFF80F0, 1'b0, 0);
    run_req("ld_hu", 1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 2, 32'h000080F0, 1'b0, 0);
    run_req("ld_rsvd", 1'b0, 2'b11, 1'b1, 32'h8, 32'h0, 2, 32'h112233AA, 1'b0, 0);
    run_req("ld_b_odd", 1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 2, 32'h00000033, 1'b0, 0);

    // Misaligned word load: bytes 6..9 are 00,00,AA,33.
`ifdef ALIGN_CHECK_EN
    run_req("ld_mis", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1, 32'h0, 1'b1, 0);
    run_req("st_mis", 1'b1, 2'b01, 1'b0, 32'hD, 32'hFFFF, 1, 32'h0, 1'b1, 0);
    check("st_mis mem", peek(32'hC), 32'h5566BEEF);
`else
    run_req("ld_mis", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 2, 32'h33AA0000, 1'b0, 0);
`endif

    // Reset during ACCESS of a byte store aborts it with no write and no response.
    poke(32'h10, 32'hCAFEBABE);
    drive(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000011);
    step();
    req_valid = 1'b0;
    check("abort in_access", 32'(req_ready), 32'd0);
    rst = 1'b1;
    step();
    check("abort we", 32'(mem_write_en), 32'd0);
    check("abort resp_valid", 32'(resp_valid), 32'd0);
    check("abort ready", 32'(req_ready), 32'd1);
    check("abort mem_address", mem_address, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort no_resp", 32'(resp_valid | mem_write_en), 32'd0);
      step();
    end
    check("abort mem", peek(32'h10), 32'hCAFEBABE);
    run_req("post_abort", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 32'h000000BE, 1'b0, 0);

    // Back-to-back with req_valid held high: the second accept waits for IDLE.
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    step();
    drive(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
    check("b2b acc1 ready", 32'(req_ready), 32'd0);
    step();
    check("b2b resp1 valid", 32'(resp_valid), 32'd1);
    check("b2b resp1 rdata", resp_rdata, 32'h112233AA);
    check("b2b resp1 ready", 32'(req_ready), 32'd0);
    step();
    check("b2b idle ready", 32'(req_ready), 32'd1);
    check("b2b idle valid", 32'(resp_valid), 32'd0);
    step();
    req_valid = 1'b0;
    check("b2b acc2 ready", 32'(req_ready), 32'd0);
    check("b2b acc2 addr", mem_address, 32'h4);
    step();
    check("b2b resp2 valid", 32'(resp_valid), 32'd1);
    check("b2b resp2 rdata", resp_rdata, 32'h000000F0);
    step();
    check("b2b end ready", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
